// File: rtl/mem_stage.sv
// Memory stage: E/M register, data-memory request/ready handshake with timeout, M/W register.
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN.
module mem_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic [3:0]       RdE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic             StallM,
  output logic             bus_err,
  output logic             RegWriteM,
  output logic [3:0]       RdM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic             PCSrcW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [3:0]       RdW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUOutW,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned RD_W   = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Payload held in the M slot
  typedef struct packed {
    logic             pcsrc;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic [RD_W-1:0]  rd;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wdata;
  } em_t;

  // Payload held in the W slot
  typedef struct packed {
    logic             pcsrc;
    logic             regwrite;
    logic             memtoreg;
    logic [RD_W-1:0]  rd;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] alu;
  } mw_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_nxt;
  em_t               r_em;
  em_t               w_em_in;
  mw_t               r_mw;
  logic              r_bus_err;
  logic              w_memop;
  logic              w_req;
  logic              w_timeout;
  logic              w_stall;
  logic              w_load_done;

  assign w_em_in = '{pcsrc:    PCSrcE,
                     regwrite: RegWriteE,
                     memtoreg: MemtoRegE,
                     memwrite: MemWriteE,
                     rd:       RdE,
                     alu:      ALUResultE,
                     wdata:    WriteDataE};

  assign w_memop = r_em.memtoreg | r_em.memwrite;

  // FSM next-state, timeout tracking and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_req       = 1'b0;
    w_timeout   = 1'b0;
    w_stall     = 1'b0;
    if (!reset) begin
      w_req = w_memop & ((r_state == S_IDLE) | (r_state == S_WAIT));
      case (r_state)
        S_IDLE: begin
          if (w_req && !dmem_ready) begin
            w_state_nxt = S_WAIT;
            w_tcnt_nxt  = '0;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            w_state_nxt = S_IDLE;
            w_tcnt_nxt  = '0;
          end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
            // Access abandoned: completes with no data and flags the bus error
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
            w_tcnt_nxt  = '0;
          end else begin
            w_tcnt_nxt = r_tcnt + TCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tcnt_nxt  = '0;
        end
      endcase
      w_stall = w_req & ~dmem_ready & ~w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // E/M register: holds the instruction in M while the access is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      r_em <= '0;
    end else if (!w_stall) begin
      r_em <= w_em_in;
    end
  end

  assign w_load_done = r_em.memtoreg & dmem_ready;

  // M/W register: bubbles during a stall, data fields keep their last value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mw <= '0;
    end else if (!w_stall) begin
      r_mw.pcsrc    <= r_em.pcsrc;
      r_mw.regwrite <= r_em.regwrite;
      r_mw.memtoreg <= r_em.memtoreg;
      r_mw.rd       <= r_em.rd;
      r_mw.alu      <= r_em.alu;
      r_mw.rdata    <= w_load_done ? dmem_rdata : '0;
    end else begin
      r_mw.pcsrc    <= 1'b0;
      r_mw.regwrite <= 1'b0;
      r_mw.memtoreg <= 1'b0;
    end
  end

  // Sticky bus error, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign dmem_req   = w_req;
  assign dmem_we    = r_em.memwrite;
  assign dmem_addr  = r_em.alu;
  assign dmem_wdata = r_em.wdata;
  assign StallM     = w_stall;
  assign bus_err    = r_bus_err;

  assign RegWriteM  = r_em.regwrite;
  assign RdM        = r_em.rd;
  assign ALUOutM    = r_em.alu;

  assign PCSrcW     = r_mw.pcsrc;
  assign RegWriteW  = r_mw.regwrite;
  assign MemtoRegW  = r_mw.memtoreg;
  assign RdW        = r_mw.rd;
  assign ReadDataW  = r_mw.rdata;
  assign ALUOutW    = r_mw.alu;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random traffic against a transaction-level model.
module tb_mem_stage;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int NEVER = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
  logic [3:0]       RdE;
  logic [WIDTH-1:0] ALUResultE, WriteDataE;
  logic             dmem_req, dmem_we, dmem_ready;
  logic [WIDTH-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic             StallM, bus_err, RegWriteM;
  logic [3:0]       RdM;
  logic [WIDTH-1:0] ALUOutM;
  logic             PCSrcW, RegWriteW, MemtoRegW;
  logic [3:0]       RdW;
  logic [WIDTH-1:0] ReadDataW, ALUOutW;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .StallM(StallM), .bus_err(bus_err),
    .RegWriteM(RegWriteM), .RdM(RdM), .ALUOutM(ALUOutM),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .RdW(RdW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .stall_cnt(stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model: instruction sitting in M, how long its access has been pending, and the expected W slot
  logic        m_pc = 0, m_rw = 0, m_mtr = 0, m_mw = 0;
  logic [3:0]  m_rd = 0;
  logic [31:0] m_alu = 0, m_wd = 0;
  int          k = 0;
  int          lat = 0;
  int          next_lat = 0;
  logic        x_pc = 0, x_rw = 0, x_mtr = 0;
  logic [3:0]  x_rd = 0;
  logic [31:0] x_rdata = 0, x_alu = 0;
  logic        x_err = 0;
  int          x_scnt = 0;
  bit          rd_fix_en = 0;
  logic [31:0] rd_fix = 0;
  int          stall_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_e(input logic pc, input logic rw, input logic mtr, input logic mw,
                       input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    PCSrcE = pc; RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw;
    RdE = rd; ALUResultE = alu; WriteDataE = wd;
  endtask

  task automatic set_nop();
    set_e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // One clock: drive memory response, check combinational handshake, then check registered state
  task automatic cycle(input bit rst);
    bit memop, exp_req, exp_stall, timeout, rdy;
    logic [31:0] rdat;
    @(negedge clk);
    reset = rst;
    memop = m_mtr | m_mw;
    rdy = memop ? (k >= lat) : 1'($urandom_range(0, 1));
    rdat = rd_fix_en ? rd_fix : $urandom;
    dmem_ready = rdy;
    dmem_rdata = rdat;
    #1;
    exp_req   = memop && !rst;
    exp_stall = exp_req && !rdy && (k < TIMEOUT);
    timeout   = exp_req && !rdy && (k == TIMEOUT);
    chk("dmem_req", 32'(dmem_req), 32'(exp_req));
    chk("StallM", 32'(StallM), 32'(exp_stall));
    if (exp_stall) stall_seen++;
    if (exp_req) begin
      chk("dmem_addr", dmem_addr, m_alu);
      chk("dmem_wdata", dmem_wdata, m_wd);
      chk("dmem_we", 32'(dmem_we), 32'(m_mw));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      {m_pc, m_rw, m_mtr, m_mw} = '0; m_rd = 0; m_alu = 0; m_wd = 0;
      {x_pc, x_rw, x_mtr} = '0; x_rd = 0; x_rdata = 0; x_alu = 0;
      x_err = 0; x_scnt = 0; k = 0; lat = 0;
    end else begin
      if (timeout) x_err = 1;
      if (exp_stall) begin
        {x_pc, x_rw, x_mtr} = '0;
        k++;
        if (x_scnt < (1 << CNT_W) - 1) x_scnt++;
      end else begin
        x_pc = m_pc; x_rw = m_rw; x_mtr = m_mtr; x_rd = m_rd; x_alu = m_alu;
        x_rdata = (m_mtr && rdy) ? rdat : 32'd0;
        m_pc = PCSrcE; m_rw = RegWriteE; m_mtr = MemtoRegE; m_mw = MemWriteE;
        m_rd = RdE; m_alu = ALUResultE; m_wd = WriteDataE;
        k = 0;
        lat = next_lat;
      end
    end
    chk("PCSrcW", 32'(PCSrcW), 32'(x_pc));
    chk("RegWriteW", 32'(RegWriteW), 32'(x_rw));
    chk("MemtoRegW", 32'(MemtoRegW), 32'(x_mtr));
    chk("RdW", 32'(RdW), 32'(x_rd));
    chk("ALUOutW", ALUOutW, x_alu);
    chk("ReadDataW", ReadDataW, x_rdata);
    chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
    chk("RdM", 32'(RdM), 32'(m_rd));
    chk("ALUOutM", ALUOutM, m_alu);
    chk("bus_err", 32'(bus_err), 32'(x_err));
`ifdef MEM_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(x_scnt));
`else
    chk("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    int r;
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    set_nop();

    // Reset state
    cycle(1);
    cycle(1);
    chk("reset_bus_err", 32'(bus_err), 32'd0);
    chk("reset_RegWriteW", 32'(RegWriteW), 32'd0);

    // ALU op passes through in two edges without touching memory
    set_e(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'h10, 32'h0);
    cycle(0);
    set_nop();
    cycle(0);
    chk("alu_RegWriteW", 32'(RegWriteW), 32'd1);
    chk("alu_RdW", 32'(RdW), 32'd3);
    chk("alu_ALUOutW", ALUOutW, 32'h10);

    // Zero-wait load
    next_lat = 0; rd_fix_en = 1; rd_fix = 32'hDEADBEEF;
    set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h40, 32'h0);
    cycle(0);
    set_nop();
    stall_seen = 0;
    cycle(0);
    rd_fix_en = 0;
    chk("zw_no_stall", 32'(stall_seen), 32'd0);
    chk("zw_ReadDataW", ReadDataW, 32'hDEADBEEF);
    chk("zw_MemtoRegW", 32'(MemtoRegW), 32'd1);

    // Store with three wait cycles
    next_lat = 3;
    set_e(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h44, 32'h55);
    cycle(0);
    set_nop();
    stall_seen = 0;
    for (int i = 0; i < 4; i++) cycle(0);
    chk("st_stall_cycles", 32'(stall_seen), 32'd3);

    // Load that never completes times out
    next_lat = NEVER;
    set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 32'h80, 32'h0);
    cycle(0);
    set_nop();
    next_lat = 0;
    stall_seen = 0;
    for (int i = 0; i <= int'(TIMEOUT); i++) cycle(0);
    chk("to_stall_cycles", 32'(stall_seen), 32'(TIMEOUT));
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_ReadDataW", ReadDataW, 32'd0);
    chk("to_MemtoRegW", 32'(MemtoRegW), 32'd1);
    cycle(0);
    chk("to_StallM_after", 32'(StallM), 32'd0);

    // Reset in the middle of a wait
    next_lat = NEVER;
    set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h90, 32'h0);
    cycle(0);
    set_nop();
    next_lat = 0;
    cycle(0);
    cycle(0);
    cycle(1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_W_ctrl", 32'({PCSrcW, RegWriteW, MemtoRegW}), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // Stall counter: three-cycle store followed by zero-wait load
    next_lat = 3;
    set_e(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h44, 32'h55);
    cycle(0);
    next_lat = 0;
    set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) cycle(0);
    set_nop();
    cycle(0);
    cycle(0);
`ifdef MEM_STALL_CNT_EN
    chk("scnt_total", 32'(stall_cnt), 32'd3);
`endif

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 19));
      next_lat = (r < 6) ? 0 : (r < 17) ? r - 5 : (r == 17) ? int'(TIMEOUT) : NEVER;
      case ($urandom_range(0, 2))
        0: set_e(1'($urandom), 1'($urandom), 1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
        1: set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'($urandom), $urandom, $urandom);
        default: set_e(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom), $urandom, $urandom);
      endcase
      cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
